// File: rtl/pwm_reg_ctrl_pkg.sv
// Register map, bit positions and helpers shared by the PWM register controller.
// Pure declarations, no latency.
// No flow control.
package pwm_reg_ctrl_pkg;

    localparam int NUM_CH_MAX = 8;

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_STATUS     = 8'h01;
    localparam logic [7:0] ADDR_PRESCALE   = 8'h02;
    localparam logic [7:0] ADDR_PERIOD     = 8'h03;
    localparam logic [7:0] ADDR_APERIOD    = 8'h04;
    localparam logic [7:0] ADDR_DUTY_BASE  = 8'h10;
    localparam logic [7:0] ADDR_ADUTY_BASE = 8'h18;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_AUTOLOAD_BIT = 1;
    localparam int CTRL_FORCE_BIT    = 7;
    localparam int STAT_PEND_BIT     = 0;
    localparam int STAT_WERR_BIT     = 1;

    // Decoded write target; REG_NONE and REG_RO both flag a write error.
    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_STATUS,
        REG_PRESCALE,
        REG_PERIOD,
        REG_DUTY,
        REG_RO
    } reg_sel_e;

    // A channel may never be asked for a duty longer than its period.
    function automatic logic [7:0] clamp_duty(input logic [7:0] duty, input logic [7:0] period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge strobe generator for a level input.
// Latency: one-cycle pulse registered the cycle after the rise is sampled.
// No flow control; history resets to INIT so a level high at release is a new edge.
module edge_detector #(
    parameter bit INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    // Track the previous level and register the rise strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= INIT;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pwm_reg_ctrl.sv
// Shadow/active register bank for the PWM core, loaded only at period boundaries or on force-load.
// Latency: write commits 1 cycle after wr_en rise is seen; active regs and load_o appear the cycle after the load.
// No backpressure: one commit per wr_en rising edge, readback is combinational from addr.
module pwm_reg_ctrl
    import pwm_reg_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            addr,
    input  logic [7:0]            data_wr,
    input  logic                  wr_en,
    output logic [7:0]            data_rd,
    input  logic                  period_end,
    output logic                  enable_o,
    output logic [7:0]            prescale_o,
    output logic [7:0]            period_o,
    output logic [8*NUM_CH-1:0]   duty_o,
    output logic                  load_o
);

    localparam int         CH_SPAN   = (NUM_CH > NUM_CH_MAX) ? NUM_CH_MAX : NUM_CH;
    localparam logic [3:0] CH_SPAN_L = 4'(CH_SPAN);

    logic                       wr_stb;
    reg_sel_e                   reg_sel;
    logic [2:0]                 ch_idx;
    logic                       ch_in_range;
    logic                       force_ld;
    logic                       load_fire;
    logic                       shadow_wr;

    logic                       en_sh_q;
    logic                       autoload_q;
    logic                       pend_q;
    logic                       wr_err_q;
    logic [7:0]                 presc_sh_q;
    logic [7:0]                 period_sh_q;
    logic [CH_SPAN-1:0][7:0]    duty_sh_q;

    logic                       en_act_q;
    logic [7:0]                 presc_act_q;
    logic [7:0]                 period_act_q;
    logic [CH_SPAN-1:0][7:0]    duty_act_q;
    logic                       load_q;

    logic [7:0]                 data_rd_d;

    edge_detector #(.INIT(1'b0)) u_wr_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (wr_en),
        .rise_o (wr_stb)
    );

    assign ch_idx      = addr[2:0];
    assign ch_in_range = ({1'b0, ch_idx} < CH_SPAN_L);

    // Classify the current address as a write target.
    always_comb begin
        reg_sel = REG_NONE;
        if (addr == ADDR_CTRL)                                        reg_sel = REG_CTRL;
        else if (addr == ADDR_STATUS)                                 reg_sel = REG_STATUS;
        else if (addr == ADDR_PRESCALE)                               reg_sel = REG_PRESCALE;
        else if (addr == ADDR_PERIOD)                                 reg_sel = REG_PERIOD;
        else if (addr == ADDR_APERIOD)                                reg_sel = REG_RO;
        else if (addr[7:3] == ADDR_DUTY_BASE[7:3] && ch_in_range)     reg_sel = REG_DUTY;
        else if (addr[7:3] == ADDR_ADUTY_BASE[7:3] && ch_in_range)    reg_sel = REG_RO;
    end

    // Load uses the pre-write autoload and shadow values; a write in the same cycle re-arms pending.
    assign force_ld  = wr_stb && (reg_sel == REG_CTRL) && data_wr[CTRL_FORCE_BIT];
    assign load_fire = (pend_q && autoload_q && period_end) || force_ld;
    assign shadow_wr = wr_stb && ((reg_sel == REG_CTRL) || (reg_sel == REG_PRESCALE) ||
                                  (reg_sel == REG_PERIOD) || (reg_sel == REG_DUTY));

    // Commit SPI writes into shadow/control/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sh_q     <= 1'b0;
            autoload_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            presc_sh_q  <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
        end else if (wr_stb) begin
            case (reg_sel)
                REG_CTRL: begin
                    en_sh_q    <= data_wr[CTRL_EN_BIT];
                    autoload_q <= data_wr[CTRL_AUTOLOAD_BIT];
                end
                REG_STATUS: begin
                    if (data_wr[STAT_WERR_BIT]) wr_err_q <= 1'b0;
                end
                REG_PRESCALE: presc_sh_q  <= data_wr;
                REG_PERIOD:   period_sh_q <= data_wr;
                REG_DUTY: begin
                    for (int n = 0; n < CH_SPAN; n++) begin
                        if (ch_idx == 3'(n)) duty_sh_q[n] <= data_wr;
                    end
                end
                default: wr_err_q <= 1'b1;
            endcase
        end
    end

    // Pending flag: set by any shadow write, cleared by a load; set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (shadow_wr) begin
            pend_q <= 1'b1;
        end else if (load_fire) begin
            pend_q <= 1'b0;
        end
    end

    // Copy shadow to active on load, clamping each duty to the shadow period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_act_q     <= 1'b0;
            presc_act_q  <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            load_q       <= 1'b0;
        end else begin
            load_q <= load_fire;
            if (load_fire) begin
                en_act_q     <= en_sh_q;
                presc_act_q  <= presc_sh_q;
                period_act_q <= period_sh_q;
                for (int n = 0; n < CH_SPAN; n++) begin
                    duty_act_q[n] <= clamp_duty(duty_sh_q[n], period_sh_q);
                end
            end
        end
    end

    // Readback mux; force-load bit and unmapped addresses read as zero.
    always_comb begin
        data_rd_d = '0;
        if (addr == ADDR_CTRL) begin
            data_rd_d[CTRL_EN_BIT]       = en_sh_q;
            data_rd_d[CTRL_AUTOLOAD_BIT] = autoload_q;
        end else if (addr == ADDR_STATUS) begin
            data_rd_d[STAT_PEND_BIT] = pend_q;
            data_rd_d[STAT_WERR_BIT] = wr_err_q;
        end else if (addr == ADDR_PRESCALE) begin
            data_rd_d = presc_sh_q;
        end else if (addr == ADDR_PERIOD) begin
            data_rd_d = period_sh_q;
        end else if (addr == ADDR_APERIOD) begin
            data_rd_d = period_act_q;
        end else begin
            for (int n = 0; n < CH_SPAN; n++) begin
                if (addr == ADDR_DUTY_BASE + 8'(n))  data_rd_d = duty_sh_q[n];
                if (addr == ADDR_ADUTY_BASE + 8'(n)) data_rd_d = duty_act_q[n];
            end
        end
    end

    assign data_rd    = data_rd_d;
    assign enable_o   = en_act_q;
    assign prescale_o = presc_act_q;
    assign period_o   = period_act_q;
    assign duty_o     = duty_act_q;
    assign load_o     = load_q;

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Directed bench for pwm_reg_ctrl with a register-level reference model.
// Model advances per clock from the documented register rules; outputs are compared every negedge.
// Literal checks at key points pin the model to hand-computed values.
module tb_pwm_reg_ctrl;

    localparam int NUM_CH = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          addr;
    logic [7:0]          data_wr;
    logic                wr_en;
    logic                period_end;
    logic [7:0]          data_rd;
    logic                enable_o;
    logic [7:0]          prescale_o;
    logic [7:0]          period_o;
    logic [8*NUM_CH-1:0] duty_o;
    logic                load_o;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int lc0;

    pwm_reg_ctrl #(.NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .data_wr    (data_wr),
        .wr_en      (wr_en),
        .data_rd    (data_rd),
        .period_end (period_end),
        .enable_o   (enable_o),
        .prescale_o (prescale_o),
        .period_o   (period_o),
        .duty_o     (duty_o),
        .load_o     (load_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic       m_en, m_auto, m_pend, m_werr;
    logic [7:0] m_presc, m_per;
    logic [7:0] m_duty [NUM_CH];
    logic       m_en_a;
    logic [7:0] m_presc_a, m_per_a;
    logic [7:0] m_duty_a [NUM_CH];
    logic       m_load;
    logic       m_level_seen;   // wr_en level observed last clock
    logic       m_commit_next;  // a fresh rise was observed: commit on the following clock

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_pend = 0; m_werr = 0;
        m_presc = 0; m_per = 0;
        m_en_a = 0; m_presc_a = 0; m_per_a = 0; m_load = 0;
        m_level_seen = 0; m_commit_next = 0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_duty[n] = 0;
            m_duty_a[n] = 0;
        end
    endtask

    task automatic model_step();
        logic commit, do_load;
        int ch;
        commit = m_commit_next;
        m_commit_next = wr_en && !m_level_seen;
        m_level_seen = wr_en;
        do_load = (m_pend && m_auto && period_end) || (commit && addr == 8'h00 && data_wr[7]);
        m_load = do_load;
        if (do_load) begin
            m_en_a = m_en;
            m_presc_a = m_presc;
            m_per_a = m_per;
            for (int n = 0; n < NUM_CH; n++)
                m_duty_a[n] = (m_duty[n] < m_per) ? m_duty[n] : m_per;
            m_pend = 0;
        end
        if (commit) begin
            ch = int'(addr) - 16;
            if (addr == 8'h00) begin
                m_en = data_wr[0]; m_auto = data_wr[1]; m_pend = 1;
            end else if (addr == 8'h01) begin
                if (data_wr[1]) m_werr = 0;
            end else if (addr == 8'h02) begin
                m_presc = data_wr; m_pend = 1;
            end else if (addr == 8'h03) begin
                m_per = data_wr; m_pend = 1;
            end else if (ch >= 0 && ch < NUM_CH) begin
                m_duty[ch] = data_wr; m_pend = 1;
            end else begin
                m_werr = 1;
            end
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int d, ad;
        d = int'(a) - 16;
        ad = int'(a) - 24;
        if (a == 8'h00) return {6'd0, m_auto, m_en};
        if (a == 8'h01) return {6'd0, m_werr, m_pend};
        if (a == 8'h02) return m_presc;
        if (a == 8'h03) return m_per;
        if (a == 8'h04) return m_per_a;
        if (d >= 0 && d < NUM_CH) return m_duty[d];
        if (ad >= 0 && ad < NUM_CH) return m_duty_a[ad];
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [8*NUM_CH-1:0] exp_duty;
        if (load_o === 1'b1) load_cnt++;
        for (int n = 0; n < NUM_CH; n++) exp_duty[n*8 +: 8] = m_duty_a[n];
        check("cyc_enable_o",   enable_o,   m_en_a);
        check("cyc_prescale_o", prescale_o, m_presc_a);
        check("cyc_period_o",   period_o,   m_per_a);
        check("cyc_duty_o",     duty_o,     exp_duty);
        check("cyc_load_o",     load_o,     m_load);
        check("cyc_data_rd",    data_rd,    model_read(addr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d, input int hold);
        tick();
        addr = a; data_wr = d; wr_en = 1'b1;
        repeat (hold) tick();
        wr_en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        @(negedge clk);
        check(name, data_rd, exp);
    endtask

    task automatic pulse_pe();
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        model_reset();
        rst_n = 1'b0; addr = 0; data_wr = 0; wr_en = 0; period_end = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state: every address reads zero, outputs idle.
        for (int a = 0; a < 32; a++) rd_chk("reset_read", 8'(a), 8'h00);
        check("reset_period", period_o, 0);
        check("reset_duty", duty_o, 0);
        check("reset_no_load", load_cnt, 0);

        // Autoload path.
        wr_reg(8'h00, 8'h02, 3);
        wr_reg(8'h03, 8'h64, 3);
        wr_reg(8'h10, 8'h20, 3);
        @(negedge clk);
        check("pre_pe_period", period_o, 8'h00);
        rd_chk("pre_pe_status", 8'h01, 8'h01);
        lc0 = load_cnt;
        pulse_pe();
        @(negedge clk);
        check("pe_period", period_o, 8'h64);
        check("pe_duty0", duty_o[7:0], 8'h20);
        check("pe_one_load", load_cnt - lc0, 1);
        rd_chk("pe_status", 8'h01, 8'h00);

        // Level-held write commits exactly once (data changed mid-hold is ignored).
        tick();
        addr = 8'h11; data_wr = 8'h10; wr_en = 1'b1;
        repeat (5) tick();
        data_wr = 8'h99;
        repeat (45) tick();
        wr_en = 1'b0;
        repeat (2) tick();
        rd_chk("hold_duty1", 8'h11, 8'h10);
        pulse_pe();
        rd_chk("aduty1", 8'h19, 8'h10);
        rd_chk("status_clean", 8'h01, 8'h00);
        wr_reg(8'h04, 8'h55, 3);
        rd_chk("aperiod_ro", 8'h04, 8'h64);
        rd_chk("werr_set", 8'h01, 8'h02);
        wr_reg(8'h01, 8'h02, 3);
        rd_chk("werr_w1c", 8'h01, 8'h00);
        wr_reg(8'h1C, 8'h12, 3);
        rd_chk("unmapped_read", 8'h1C, 8'h00);
        rd_chk("unmapped_werr", 8'h01, 8'h02);
        wr_reg(8'h01, 8'h02, 3);

        // Force-load with duty clamp.
        wr_reg(8'h03, 8'h30, 3);
        wr_reg(8'h12, 8'hF0, 3);
        lc0 = load_cnt;
        wr_reg(8'h00, 8'h80, 3);
        @(negedge clk);
        check("force_one_load", load_cnt - lc0, 1);
        check("force_duty2_clamp", duty_o[23:16], 8'h30);
        check("force_period", period_o, 8'h30);
        rd_chk("ctrl_force_reads0", 8'h00, 8'h00);

        // Force-load held for 50 cycles fires once.
        lc0 = load_cnt;
        wr_reg(8'h00, 8'h82, 50);
        check("force_hold_one_load", load_cnt - lc0, 1);
        pulse_pe();

        // Write commit coincides with period_end: load takes old shadow.
        wr_reg(8'h02, 8'h07, 3);
        tick();
        addr = 8'h10; data_wr = 8'h28; wr_en = 1'b1;
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("coll_duty0_old", duty_o[7:0], 8'h20);
        check("coll_prescale", prescale_o, 8'h07);
        rd_chk("coll_pending", 8'h01, 8'h01);
        pulse_pe();
        @(negedge clk);
        check("coll_duty0_new", duty_o[7:0], 8'h28);

        // Reset mid-write with a pending load.
        wr_reg(8'h03, 8'h50, 3);
        tick();
        addr = 8'h13; data_wr = 8'h0A; wr_en = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_period", period_o, 0);
        check("rst_duty", duty_o, 0);
        check("rst_prescale", prescale_o, 0);
        check("rst_load", load_o, 0);
        check("rst_read", data_rd, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        data_wr = 8'h0B;
        repeat (5) tick();
        wr_en = 1'b0;
        tick();
        rd_chk("rel_duty3_once", 8'h13, 8'h0A);
        rd_chk("rel_status", 8'h01, 8'h01);
        rd_chk("rel_period_zero", 8'h03, 8'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
